mem_port_arbiter: RTL and testbench

Shares the single-port instruction/data SRAM macro between two requesters: the instruction-cache refill path (multi-word line bursts) and the data-memory path (single-word reads and writes). It sits between the cache-miss FSM / load-store unit and the SRAM. It drives the macro's active-low chip-select and write-enable, and tags each read so its response returns to the correct requester after a fixed SRAM latency. Data accesses have priority; a starvation counter guarantees refill progress.

---
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port SRAM between i-cache refill bursts and
//            data accesses, with response tagging and refill anti-starvation.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 2,
    parameter int LINE_WORDS = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_last,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_csb,
    output logic              mem_web,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int LW = $clog2(LINE_WORDS);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [LW-1:0] c_LAST       = LW'(LINE_WORDS - 1);
    localparam logic [SW-1:0] c_STARVE_MAX = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_IBURST = 2'd1,
        S_DACC   = 2'd2
    } state_t;

    state_t               state_q;
    logic [LW-1:0]        cnt_q;
    logic [SW-1:0]        starve_q;
    logic [ADDR_W-LW-1:0] base_q;
    logic                 mem_csb_q;
    logic                 mem_web_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [DATA_W-1:0]    mem_wdata_q;
    logic                 i_gnt_q;
    logic                 d_gnt_q;
    logic [RD_LAT-1:0]    tag_v_q;
    logic [RD_LAT-1:0]    tag_o_q;
    logic [RD_LAT-1:0]    tag_l_q;

    logic tag_v_d;
    logic tag_o_d;
    logic tag_l_d;
    logic w_unused_lsb;

    // Tag describing the access happening this cycle; DACC reads are web=1.
    assign tag_v_d = (state_q == S_IBURST) || ((state_q == S_DACC) && mem_web_q);
    assign tag_o_d = (state_q == S_IBURST);
    assign tag_l_d = (state_q == S_IBURST) && (cnt_q == c_LAST);
    assign w_unused_lsb = ^i_addr[LW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            starve_q    <= '0;
            base_q      <= '0;
            mem_csb_q   <= 1'b1;
            mem_web_q   <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            tag_v_q     <= '0;
            tag_o_q     <= '0;
            tag_l_q     <= '0;
        end else begin
            tag_v_q[0] <= tag_v_d;
            tag_o_q[0] <= tag_o_d;
            tag_l_q[0] <= tag_l_d;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_o_q[i] <= tag_o_q[i-1];
                tag_l_q[i] <= tag_l_q[i-1];
            end

            case (state_q)
                S_IDLE: begin
                    if (!i_req) begin
                        starve_q <= '0;
                    end
                    if (d_req && (!i_req || (starve_q < c_STARVE_MAX))) begin
                        state_q     <= S_DACC;
                        mem_csb_q   <= 1'b0;
                        mem_web_q   <= ~d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        d_gnt_q     <= 1'b1;
                    end else if (i_req) begin
                        state_q    <= S_IBURST;
                        cnt_q      <= '0;
                        starve_q   <= '0;
                        base_q     <= i_addr[ADDR_W-1:LW];
                        mem_csb_q  <= 1'b0;
                        mem_web_q  <= 1'b1;
                        mem_addr_q <= {i_addr[ADDR_W-1:LW], {LW{1'b0}}};
                        i_gnt_q    <= 1'b1;
                    end
                end
                S_DACC: begin
                    state_q   <= S_IDLE;
                    mem_csb_q <= 1'b1;
                    mem_web_q <= 1'b1;
                    d_gnt_q   <= 1'b0;
                    if (i_req && (starve_q < c_STARVE_MAX)) begin
                        starve_q <= starve_q + SW'(1);
                    end
                end
                S_IBURST: begin
                    i_gnt_q <= 1'b0;
                    if (cnt_q == c_LAST) begin
                        state_q   <= S_IDLE;
                        mem_csb_q <= 1'b1;
                    end else begin
                        cnt_q      <= cnt_q + LW'(1);
                        mem_addr_q <= {base_q, cnt_q + LW'(1)};
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_csb_q <= 1'b1;
                    mem_web_q <= 1'b1;
                end
            endcase
        end
    end

    assign mem_csb   = mem_csb_q;
    assign mem_web   = mem_web_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_gnt     = i_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign i_rvalid  = tag_v_q[RD_LAT-1] & tag_o_q[RD_LAT-1];
    assign d_rvalid  = tag_v_q[RD_LAT-1] & ~tag_o_q[RD_LAT-1];
    assign i_last    = i_rvalid & tag_l_q[RD_LAT-1];
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign busy      = (state_q != S_IDLE) || (|tag_v_q);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter with an SRAM
//            model of two-cycle read latency.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req, d_req, d_we;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              i_gnt, i_rvalid, i_last, d_gnt, d_rvalid;
    logic [DATA_W-1:0] i_rdata, d_rdata;
    logic              mem_csb, mem_web, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2), .LINE_WORDS(4), .STARVE_MAX(3)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_last(i_last),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_csb(mem_csb), .mem_web(mem_web), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // SRAM model: address captured at the end of the access cycle, data
    // appears two cycles after that access cycle.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd0 = '0;
    logic [DATA_W-1:0] rd1 = '0;
    assign mem_rdata = rd1;
    always @(posedge clk) begin
        if (!mem_csb && !mem_web) mem[mem_addr] <= mem_wdata;
        rd0 <= (!mem_csb && mem_web) ? mem[mem_addr] : 32'h0;
        rd1 <= rd0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        int n_d;
        int waited;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
        mem[10'h010] = 32'hDEADBEEF;
        mem[10'h030] = 32'hCAFEF00D;
        for (int k = 0; k < 4; k++) begin
            mem[10'h040 + k] = 32'hA000_0040 + k;
            mem[10'h080 + k] = 32'hB000_0080 + k;
        end
        rst = 1'b1; i_req = 0; d_req = 0; d_we = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;

        // Reset state
        repeat (2) cyc();
        check("rst_csb", mem_csb, 1);
        check("rst_web", mem_web, 1);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_gnts", {i_gnt, d_gnt, i_rvalid, d_rvalid, i_last}, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // 1: data read
        cyc();
        d_req = 1; d_we = 0; d_addr = 10'h010;
        cyc();
        check("t1_dgnt", d_gnt, 1);
        check("t1_csb_web", {mem_csb, mem_web}, 2'b01);
        check("t1_addr", mem_addr, 10'h010);
        d_req = 0;
        cyc();
        check("t1_rvalid_early", d_rvalid, 0);
        check("t1_dgnt_pulse", d_gnt, 0);
        cyc();
        check("t1_rvalid", {d_rvalid, i_rvalid}, 2'b10);
        check("t1_rdata", d_rdata, 32'hDEADBEEF);

        // 2: data write
        cyc();
        d_req = 1; d_we = 1; d_addr = 10'h020; d_wdata = 32'h12345678;
        cyc();
        check("t2_dgnt", d_gnt, 1);
        check("t2_csb_web", {mem_csb, mem_web}, 2'b00);
        check("t2_addr", mem_addr, 10'h020);
        check("t2_wdata", mem_wdata, 32'h12345678);
        d_req = 0; d_we = 0;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            check("t2_no_rvalid", d_rvalid, 0);
            check("t2_web_high", mem_web, 1);
        end
        check("t2_mem", mem[10'h020], 32'h12345678);

        // 3: refill burst
        i_req = 1; i_addr = 10'h043;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            if (c == 1) i_req = 0;
            if (c <= 4) begin
                check("t3_addr", mem_addr, 10'h040 + c - 1);
                check("t3_csb_web", {mem_csb, mem_web}, 2'b01);
            end else begin
                check("t3_csb_idle", mem_csb, 1);
            end
            check("t3_ignt", i_gnt, (c == 1));
            check("t3_irvalid", i_rvalid, (c >= 3 && c <= 6));
            check("t3_ilast", i_last, (c == 6));
            if (c >= 3 && c <= 6) check("t3_idata", i_rdata, 32'hA000_0040 + c - 3);
        end
        check("t3_busy_end", busy, 0);

        // 4: both held, starvation bound
        d_req = 1; d_we = 0; d_addr = 10'h010; i_req = 1; i_addr = 10'h040;
        n_d = 0; waited = 0;
        while (waited < 20) begin
            cyc();
            waited++;
            if (d_gnt) n_d++;
            if (i_gnt) break;
        end
        check("t4_igi_seen", i_gnt, 1);
        check("t4_dgnt_count", n_d, 3);
        i_req = 0;
        waited = 0;
        while (waited < 10) begin
            cyc();
            waited++;
            if (d_gnt) break;
        end
        check("t4_dgnt_after", d_gnt, 1);
        check("t4_dgnt_delay", waited, 5);
        check("t4_starve", dut.starve_q, 0);
        d_req = 0;
        repeat (4) cyc();

        // 5: data request raised mid-burst
        i_req = 1; i_addr = 10'h080;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            if (c == 1) begin
                i_req = 0; d_req = 1; d_we = 0; d_addr = 10'h030;
            end
            if (c == 6) begin
                d_req = 0;
                check("t5_daddr", mem_addr, 10'h030);
            end
            check("t5_dgnt", d_gnt, (c == 6));
            check("t5_ilast", i_last, (c == 6));
            check("t5_drvalid", d_rvalid, (c == 8));
            check("t5_no_overlap", i_rvalid & d_rvalid, 0);
        end
        check("t5_ddata", d_rdata, 32'hCAFEF00D);
        repeat (2) cyc();

        // 6: reset mid-burst
        i_req = 1; i_addr = 10'h040;
        cyc();
        check("t6_igi", i_gnt, 1);
        i_req = 0;
        cyc();
        rst = 1;
        cyc();
        rst = 0;
        check("t6_csb", mem_csb, 1);
        check("t6_busy", busy, 0);
        check("t6_starve", dut.starve_q, 0);
        check("t6_irvalid0", i_rvalid, 0);
        for (int c = 0; c < 3; c++) begin
            cyc();
            check("t6_irvalid", i_rvalid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
